// File: rtl/plm_port_driver_pkg.sv
// ============================================================================
// Module  : plm_port_driver_pkg
// Brief   : Shared saladin definitions: PLM geometry and the grant payload.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package plm_port_driver_pkg;

    localparam int DEF_NCONSUMERS  = 16;
    localparam int DEF_NBANKS      = 4;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_VALUE_WIDTH = 8;

    localparam int LADDR_W         = DEF_ADDR_WIDTH - $clog2(DEF_NBANKS);
    localparam int VALUE_WIDTH     = DEF_VALUE_WIDTH;
    localparam int PLM_INPUT_WIDTH = LADDR_W + VALUE_WIDTH + 1;
    localparam int CID_W           = $clog2(DEF_NCONSUMERS);

    // Field order places the write flag in the LSB of the flattened vector.
    typedef struct packed {
        logic [LADDR_W-1:0]     local_addr;
        logic [VALUE_WIDTH-1:0] value;
        logic                   write;
    } plm_req_t;

endpackage

`default_nettype wire

// File: rtl/plm_port_if.sv
// ============================================================================
// Module  : plm_port_if
// Brief   : Grant, bank-port and read-response signals of one PLM port driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface plm_port_if #(
    parameter int CID_W       = plm_port_driver_pkg::CID_W,
    parameter int LADDR_W     = plm_port_driver_pkg::LADDR_W,
    parameter int VALUE_WIDTH = plm_port_driver_pkg::VALUE_WIDTH
);
    localparam int PLM_INPUT_WIDTH = LADDR_W + VALUE_WIDTH + 1;

    logic                       grant_valid;
    logic [CID_W-1:0]           grant_consumer;
    logic [PLM_INPUT_WIDTH-1:0] grant_plm;
    logic                       port_ready;

    logic                       mem_en;
    logic                       mem_we;
    logic [LADDR_W-1:0]         mem_addr;
    logic [VALUE_WIDTH-1:0]     mem_wdata;
    logic [VALUE_WIDTH-1:0]     mem_rdata;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [CID_W-1:0]           rsp_consumer;
    logic [VALUE_WIDTH-1:0]     rsp_data;

    modport master (
        output grant_valid, grant_consumer, grant_plm, mem_rdata, rsp_ready,
        input  port_ready, mem_en, mem_we, mem_addr, mem_wdata,
        input  rsp_valid, rsp_consumer, rsp_data
    );

    modport slave (
        input  grant_valid, grant_consumer, grant_plm, mem_rdata, rsp_ready,
        output port_ready, mem_en, mem_we, mem_addr, mem_wdata,
        output rsp_valid, rsp_consumer, rsp_data
    );

endinterface

`default_nettype wire

// File: rtl/plm_rsp_fifo.sv
// ============================================================================
// Module  : plm_rsp_fifo
// Brief   : In-order response FIFO, any DEPTH, push and pop allowed when full.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module plm_rsp_fifo
    import plm_port_driver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_push_data,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_head,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + c_ptr_w'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= f_next(r_wptr);
            if (i_pop)  r_rptr <= f_next(r_rptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/plm_port_driver.sv
// ============================================================================
// Module  : plm_port_driver
// Brief   : Drives one PLM bank port from granted requests and returns read
//           data in order. Define PLM_PORT_STATS_EN for read/write counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module plm_port_driver
    import plm_port_driver_pkg::*;
#(
    parameter int NCONSUMERS   = DEF_NCONSUMERS,
    parameter int NBANKS       = DEF_NBANKS,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int VALUE_WIDTH  = DEF_VALUE_WIDTH,
    parameter int READ_LATENCY = 2,
    parameter int RSP_DEPTH    = 4
) (
    input  wire logic clk,
    input  wire logic reset,
`ifdef PLM_PORT_STATS_EN
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
`endif
    plm_port_if.slave bus
);
    localparam int          c_laddr_w = ADDR_WIDTH - $clog2(NBANKS);
    localparam int          c_cid_w   = $clog2(NCONSUMERS);
    localparam int          c_plm_w   = c_laddr_w + VALUE_WIDTH + 1;
    localparam int          c_rsp_w   = c_cid_w + VALUE_WIDTH;
    localparam int          c_cnt_w   = $clog2(RSP_DEPTH + 1);
    localparam int unsigned c_depth   = RSP_DEPTH;

    logic                   w_accept;
    logic                   w_write;
    logic                   w_pop;
    logic [c_laddr_w-1:0]   w_addr;
    logic [VALUE_WIDTH-1:0] w_value;
    logic [c_cnt_w-1:0]     w_fifo_count;
    logic                   w_fifo_empty;
    logic [c_rsp_w-1:0]     w_head;
    int unsigned            w_inflight;

    logic                   r_mem_en;
    logic                   r_mem_we;
    logic [c_laddr_w-1:0]   r_mem_addr;
    logic [VALUE_WIDTH-1:0] r_mem_wdata;
    logic [READ_LATENCY-1:0] r_tag_vld;
    logic [c_cid_w-1:0]     r_tag_cid [READ_LATENCY];

    assign w_write = bus.grant_plm[0];
    assign w_value = bus.grant_plm[VALUE_WIDTH:1];
    assign w_addr  = bus.grant_plm[c_plm_w-1 -: c_laddr_w];

    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < READ_LATENCY; i++) w_inflight += 32'(r_tag_vld[i]);
    end

    // Every accepted read owns a FIFO slot from acceptance until it is popped.
    assign bus.port_ready = !reset && ((32'(w_fifo_count) + w_inflight) < c_depth);
    assign w_accept       = bus.grant_valid && bus.port_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_accept;
            r_mem_we <= w_accept && w_write;
            if (w_accept) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_value;
            end
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_vld <= '0;
        end else begin
            r_tag_vld[0] <= w_accept && !w_write;
            for (int i = 1; i < READ_LATENCY; i++) r_tag_vld[i] <= r_tag_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_tag_cid[0] <= bus.grant_consumer;
        for (int i = 1; i < READ_LATENCY; i++) r_tag_cid[i] <= r_tag_cid[i-1];
    end

    plm_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (c_rsp_w)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (r_tag_vld[READ_LATENCY-1]),
        .i_push_data ({r_tag_cid[READ_LATENCY-1], bus.mem_rdata}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Head is masked while empty so stale storage never leaks after reset.
    assign bus.rsp_valid    = !w_fifo_empty;
    assign w_pop            = !w_fifo_empty && bus.rsp_ready;
    assign bus.rsp_consumer = w_fifo_empty ? '0 : w_head[c_rsp_w-1 -: c_cid_w];
    assign bus.rsp_data     = w_fifo_empty ? '0 : w_head[VALUE_WIDTH-1:0];

`ifdef PLM_PORT_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
        end else if (w_accept) begin
            if (w_write) r_stat_writes <= r_stat_writes + 32'd1;
            else         r_stat_reads  <= r_stat_reads + 32'd1;
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
`endif

endmodule

`default_nettype wire

// File: tb/tb_plm_port_driver.sv
// ============================================================================
// Module  : tb_plm_port_driver
// Brief   : Self-checking bench for plm_port_driver (directed table, corner
//           sequences, random traffic against an outstanding-read model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plm_port_driver;
    import plm_port_driver_pkg::*;

    localparam int L = 2;
    localparam int D = 4;
    localparam int MEMSZ = 1 << LADDR_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    plm_port_if #(.CID_W(CID_W), .LADDR_W(LADDR_W), .VALUE_WIDTH(VALUE_WIDTH)) bus ();

`ifdef PLM_PORT_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
`endif

    plm_port_driver #(
        .NCONSUMERS(16), .NBANKS(4), .ADDR_WIDTH(16), .VALUE_WIDTH(8),
        .READ_LATENCY(L), .RSP_DEPTH(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef PLM_PORT_STATS_EN
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
`endif
        .bus         (bus)
    );

    // Bank memory: synchronous RAM, read data one cycle after the enable.
    logic [7:0] mem [0:MEMSZ-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    typedef struct {
        logic       rst;
        logic       gv;
        logic [3:0] cid;
        logic [13:0] addr;
        logic [7:0] val;
        logic       wr;
        logic       rr;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       e_ready;
        logic       e_en;
        logic       e_valid;
        logic [3:0] e_cid;
        logic [7:0] e_data;
    } vec_t;

    typedef struct {
        logic [3:0] cid;
        logic [7:0] data;
        int         vis;
    } rsp_t;

    // Reference: every accepted read is outstanding until popped; it becomes
    // visible L+1 cycles after acceptance, in acceptance order.
    rsp_t       q[$];
    logic [7:0] sh [0:MEMSZ-1];
    logic       m_en, m_we;
    logic [13:0] m_addr;
    logic [7:0] m_wdata;
    logic       prev_rst;
    int         cyc;
    int         checks = 0;
    int         errors = 0;

    function automatic stim_t S(input int rst, input int gv, input int cid, input int addr,
                                input int val, input int wr, input int rr);
        stim_t s;
        s.rst = (rst != 0); s.gv = (gv != 0); s.cid = 4'(cid); s.addr = 14'(addr);
        s.val = 8'(val); s.wr = (wr != 0); s.rr = (rr != 0);
        return s;
    endfunction

    function automatic vec_t V(input stim_t s, input int er, input int een, input int ev,
                               input int ec, input int ed);
        vec_t v;
        v.s = s; v.e_ready = (er != 0); v.e_en = (een != 0); v.e_valid = (ev != 0);
        v.e_cid = 4'(ec); v.e_data = 8'(ed);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input stim_t s, output logic a_ready, output logic a_en,
                        output logic a_valid, output logic [3:0] a_cid, output logic [7:0] a_data);
        plm_req_t req;
        logic e_ready, e_valid;
        @(negedge clk);
        reset              = s.rst;
        bus.grant_valid    = s.gv;
        bus.grant_consumer = s.cid;
        req.local_addr     = s.addr;
        req.value          = s.val;
        req.write          = s.wr;
        bus.grant_plm      = req;
        bus.rsp_ready      = s.rr;
        #1;
        e_ready = !s.rst && (q.size() < D);
        e_valid = (q.size() > 0) && (q[0].vis <= cyc);
        a_ready = bus.port_ready;
        a_en    = bus.mem_en;
        a_valid = bus.rsp_valid;
        a_cid   = bus.rsp_consumer;
        a_data  = bus.rsp_data;
        chk("port_ready", 32'(a_ready), 32'(e_ready));
        chk("rsp_valid", 32'(a_valid), 32'(e_valid));
        chk("mem_en", 32'(a_en), 32'(m_en));
        if (m_en) begin
            chk("mem_we", 32'(bus.mem_we), 32'(m_we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
        end
        if (e_valid) begin
            chk("rsp_consumer", 32'(a_cid), 32'(q[0].cid));
            chk("rsp_data", 32'(a_data), 32'(q[0].data));
        end
        if (s.rst && prev_rst) begin
            chk("rst_mem_we", 32'(bus.mem_we), 0);
            chk("rst_mem_addr", 32'(bus.mem_addr), 0);
            chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
            chk("rst_rsp_consumer", 32'(a_cid), 0);
            chk("rst_rsp_data", 32'(a_data), 0);
        end
        @(posedge clk);
        if (s.rst) begin
            q.delete();
            m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        end else begin
            if (e_valid && s.rr) void'(q.pop_front());
            m_en = s.gv && e_ready;
            m_we = m_en && s.wr;
            if (m_en) begin
                m_addr  = s.addr;
                m_wdata = s.val;
                if (s.wr) sh[s.addr] = s.val;
                else      q.push_back('{cid: s.cid, data: sh[s.addr], vis: cyc + L + 1});
            end
        end
        prev_rst = s.rst;
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        logic ar, ae, av;
        logic [3:0] ac;
        logic [7:0] ad;
        int acc, nxt, npop, stale;
        logic [3:0] popped[8];

        for (int a = 0; a < MEMSZ; a++) begin
            mem[a] = 8'(a * 7 + 3);
            sh[a]  = 8'(a * 7 + 3);
        end
        reset = 1'b1; bus.grant_valid = 1'b0; bus.grant_consumer = '0;
        bus.grant_plm = '0; bus.rsp_ready = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        q.delete(); m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        prev_rst = 1'b1; cyc = 0;

        // Reset hold, single write, single read with back-pressured response.
        tbl[0] = V(S(1, 1, 3, 5, 9, 0, 1), 0, 0, 0, 0, 0);
        tbl[1] = V(S(1, 1, 3, 5, 9, 0, 1), 0, 0, 0, 0, 0);
        tbl[2] = V(S(0, 1, 0, 2, 25, 1, 1), 1, 0, 0, 0, 0);
        tbl[3] = V(S(0, 1, 5, 2, 0, 0, 1), 1, 1, 0, 0, 0);
        tbl[4] = V(S(0, 0, 0, 0, 0, 0, 1), 1, 1, 0, 0, 0);
        tbl[5] = V(S(0, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0, 0);
        tbl[6] = V(S(0, 0, 0, 0, 0, 0, 0), 1, 0, 1, 5, 25);
        tbl[7] = V(S(0, 0, 0, 0, 0, 0, 1), 1, 0, 1, 5, 25);
        tbl[8] = V(S(0, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].s, ar, ae, av, ac, ad);
            chk($sformatf("tbl%0d.ready", i), 32'(ar), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d.mem_en", i), 32'(ae), 32'(tbl[i].e_en));
            chk($sformatf("tbl%0d.rsp_valid", i), 32'(av), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d.rsp_consumer", i), 32'(ac), 32'(tbl[i].e_cid));
                chk($sformatf("tbl%0d.rsp_data", i), 32'(ad), 32'(tbl[i].e_data));
            end
        end

        // Credit exhaustion under back-pressure, then a single pop.
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            step(S(0, 1, k, 40 + k, 0, 0, 0), ar, ae, av, ac, ad);
            if (ar) acc++;
        end
        chk("bp_accepted", 32'(acc), 4);
        chk("bp_ready_low", 32'(ar), 0);
        step(S(0, 1, 8, 60, 0, 0, 1), ar, ae, av, ac, ad);
        chk("bp_pop_valid", 32'(av), 1);
        chk("bp_ready_during_pop", 32'(ar), 0);
        step(S(0, 1, 9, 61, 0, 0, 0), ar, ae, av, ac, ad);
        chk("bp_ready_back", 32'(ar), 1);
        for (int k = 0; k < 12; k++) step(S(0, 0, 0, 0, 0, 0, 1), ar, ae, av, ac, ad);

        // Full FIFO, then concurrent push/pop across pointer wrap.
        nxt = 0; npop = 0;
        for (int k = 0; k < 80 && npop < 8; k++) begin
            step(S(0, (nxt < 8) ? 1 : 0, nxt, 100 + nxt, 0, 0, (k >= 6) ? 1 : 0), ar, ae, av, ac, ad);
            if (nxt < 8 && ar) nxt++;
            if (av && k >= 6) begin
                popped[npop] = ac;
                npop++;
            end
        end
        chk("wrap_pops", 32'(npop), 8);
        for (int i = 0; i < npop; i++) chk($sformatf("wrap_order%0d", i), 32'(popped[i]), 32'(i));

        // Reset with two reads queued and two in flight.
        for (int k = 0; k < 4; k++) step(S(0, 1, 10 + k, 200 + k, 0, 0, 0), ar, ae, av, ac, ad);
        step(S(1, 0, 0, 0, 0, 0, 0), ar, ae, av, ac, ad);
        chk("rst_valid_before", 32'(av), 1);
        step(S(1, 0, 0, 0, 0, 0, 0), ar, ae, av, ac, ad);
        step(S(0, 0, 0, 0, 0, 0, 1), ar, ae, av, ac, ad);
        chk("rst_ready_after", 32'(ar), 1);
        chk("rst_valid_after", 32'(av), 0);
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            step(S(0, 0, 0, 0, 0, 0, 1), ar, ae, av, ac, ad);
            if (av) stale++;
        end
        chk("rst_no_stale", 32'(stale), 0);

        // Random traffic on a small address window so reads see fresh writes.
        for (int k = 0; k < 400; k++) begin
            step(S(($urandom_range(0, 59) == 0) ? 1 : 0,
                   ($urandom_range(0, 3) != 0) ? 1 : 0,
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 255)),
                   ($urandom_range(0, 2) == 0) ? 1 : 0,
                   (((k / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0)) ? 1 : 0),
                 ar, ae, av, ac, ad);
        end

`ifdef PLM_PORT_STATS_EN
        step(S(1, 0, 0, 0, 0, 0, 1), ar, ae, av, ac, ad);
        step(S(1, 0, 0, 0, 0, 0, 1), ar, ae, av, ac, ad);
        #1;
        chk("stat_reads_rst", stat_reads, 0);
        chk("stat_writes_rst", stat_writes, 0);
        step(S(0, 1, 1, 300, 0, 0, 1), ar, ae, av, ac, ad);
        step(S(0, 1, 2, 301, 7, 1, 1), ar, ae, av, ac, ad);
        step(S(0, 1, 3, 302, 0, 0, 1), ar, ae, av, ac, ad);
        step(S(0, 1, 4, 303, 8, 1, 1), ar, ae, av, ac, ad);
        step(S(0, 1, 5, 304, 0, 0, 1), ar, ae, av, ac, ad);
        for (int k = 0; k < 6; k++) step(S(0, 0, 0, 0, 0, 0, 1), ar, ae, av, ac, ad);
        #1;
        chk("stat_reads", stat_reads, 3);
        chk("stat_writes", stat_writes, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
